// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types for the branch resolution path
package bp_pkg;

  localparam int REC_XLEN  = 32;
  localparam int REC_IDX_W = 6;
  localparam int PC_STEP   = 4;

  typedef struct packed {
    logic [REC_XLEN-1:0]  pc;
    logic                 taken;
    logic [REC_XLEN-1:0]  target;
    logic [REC_IDX_W-1:0] idx;
  } pred_rec_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bru_state_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// rtl/bru_pred_fifo.sv - in-order queue of in-flight predictions
module bru_pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  pred_rec_t     push_rec,
  output pred_rec_t     head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  pred_rec_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_rec;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - checks predictions against outcomes, redirects and trains
// Optional macro BRU_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int XLEN  = REC_XLEN,
  parameter int DEPTH = 4,
  parameter int IDX_W = REC_IDX_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [XLEN-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_taken,
  input  logic [XLEN-1:0]  res_target,
  output logic             flush_valid,
  output logic [XLEN-1:0]  flush_pc,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             upd_mispredict
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  bru_state_t      state;
  pred_rec_t       push_rec;
  pred_rec_t       head;
  logic [CW-1:0]   count;
  logic            push;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  assign pred_ready = (state == RUN) && (count < CW'(DEPTH));
  assign res_ready  = (state == RUN) && (count != '0);
  assign push       = pred_valid && pred_ready;
  assign resolve    = res_valid && res_ready;

  assign push_rec = '{pc: pred_pc, taken: pred_taken, target: pred_target, idx: pred_idx};

  assign mispredict  = (res_taken != head.taken) ||
                       (res_taken && (res_target != head.target));
  assign redirect_pc = res_taken ? res_target : head.pc + XLEN'(PC_STEP);

  // A mispredict wipes the whole queue, including any push landing in the same cycle
  bru_pred_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (resolve && !mispredict),
    .clear    (resolve && mispredict),
    .push_rec (push_rec),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      flush_valid    <= 1'b0;
      flush_pc       <= '0;
      upd_valid      <= 1'b0;
      upd_idx        <= '0;
      upd_taken      <= 1'b0;
      upd_mispredict <= 1'b0;
    end else begin
      upd_valid      <= resolve;
      upd_idx        <= resolve ? head.idx : '0;
      upd_taken      <= resolve && res_taken;
      upd_mispredict <= resolve && mispredict;
      flush_valid    <= resolve && mispredict;
      flush_pc       <= (resolve && mispredict) ? redirect_pc : '0;
      case (state)
        RUN:     if (resolve && mispredict) state <= FLUSH;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (resolve) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random bench for branch_resolve_unit
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        pred_valid = 1'b0;
  logic        pred_ready;
  logic [31:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic [5:0]  pred_idx = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = '0;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispredict;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_resolve_unit #(.XLEN(32), .DEPTH(DEPTH), .IDX_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_idx       (pred_idx),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_taken      (res_taken),
    .res_target     (res_target),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
    logic [5:0]  idx;
  } mrec_t;

  mrec_t       mq[$];
  bit          m_flush;
  int unsigned m_br;
  int unsigned m_mis;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $error("FAIL timeout: test did not finish in time");
    $finish;
  end

  task automatic step(input bit pv, input logic [31:0] ppc, input bit pt,
                      input logic [31:0] ptgt, input logic [5:0] pidx,
                      input bit rv, input bit rt, input logic [31:0] rtgt);
    bit          exp_pr, exp_rr, acc_push, acc_res, mis;
    mrec_t       h;
    logic [31:0] fpc;
    pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt; pred_idx = pidx;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    #1;
    exp_pr = !m_flush && (mq.size() < DEPTH);
    exp_rr = !m_flush && (mq.size() != 0);
    chk("pred_ready", pred_ready, exp_pr);
    chk("res_ready", res_ready, exp_rr);
    acc_push = pv && exp_pr;
    acc_res  = rv && exp_rr;
    mis = 1'b0;
    fpc = '0;
    h = '{pc: '0, taken: 1'b0, target: '0, idx: '0};
    if (acc_res) begin
      h = mq[0];
      mis = (rt != h.taken) || (rt && rtgt != h.target);
      fpc = rt ? rtgt : h.pc + 32'd4;
      m_br++;
      if (mis) m_mis++;
    end
    if (acc_res && mis) mq.delete();
    else begin
      if (acc_res) void'(mq.pop_front());
      if (acc_push) mq.push_back('{pc: ppc, taken: pt, target: ptgt, idx: pidx});
    end
    m_flush = acc_res && mis;
    @(posedge clock);
    #1;
    chk("upd_valid", upd_valid, acc_res);
    chk("flush_valid", flush_valid, acc_res && mis);
    if (acc_res) begin
      chk("upd_idx", upd_idx, h.idx);
      chk("upd_taken", upd_taken, rt);
      chk("upd_mispredict", upd_mispredict, mis);
      if (mis) chk("flush_pc", flush_pc, fpc);
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_only(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                           input logic [5:0] idx);
    step(1'b1, pc, t, tgt, idx, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve_only(input bit t, input logic [31:0] tgt);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, t, tgt);
  endtask

  task automatic check_outputs_zero(input string where);
    chk({where, "_flush_valid"}, flush_valid, 1'b0);
    chk({where, "_flush_pc"}, flush_pc, 32'h0);
    chk({where, "_upd_valid"}, upd_valid, 1'b0);
    chk({where, "_upd_idx"}, upd_idx, 6'h0);
    chk({where, "_upd_taken"}, upd_taken, 1'b0);
    chk({where, "_upd_mispredict"}, upd_mispredict, 1'b0);
  endtask

  task automatic do_reset();
    pred_valid = 1'b0;
    res_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("reset");
    mq.delete();
    m_flush = 1'b0;
    m_br = 0;
    m_mis = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit          rv, rt, pt;
    logic [31:0] rtgt, ptgt;
    m_flush = 1'b0;
    m_br = 0;
    m_mis = 0;
    @(posedge clock);
    #1;
    do_reset();
    chk("reset_pred_ready", pred_ready, 1'b1);
    chk("reset_res_ready", res_ready, 1'b0);

    push_only(32'h100, 1'b1, 32'h200, 6'd1);
    resolve_only(1'b1, 32'h200);
    idle();

    push_only(32'h100, 1'b0, 32'h0, 6'd2);
    resolve_only(1'b1, 32'h180);
    idle();
    idle();

    push_only(32'h104, 1'b1, 32'h300, 6'd3);
    resolve_only(1'b0, 32'h0);
    idle();

    for (int i = 0; i < DEPTH; i++) push_only(32'h400 + 32'(i * 8), 1'b0, '0, 6'(10 + i));
    push_only(32'h500, 1'b0, '0, 6'd20);
    step(1'b1, 32'h600, 1'b0, '0, 6'd21, 1'b1, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) resolve_only(1'b0, '0);
    idle();

    for (int i = 0; i < 3; i++) push_only(32'h700 + 32'(i * 4), 1'b0, '0, 6'(30 + i));
    step(1'b1, 32'h800, 1'b1, 32'h900, 6'd40, 1'b1, 1'b1, 32'h7f0);
    idle();
    idle();

    push_only(32'hFFFF_FFFC, 1'b1, 32'h10, 6'd50);
    resolve_only(1'b0, '0);
    idle();

    push_only(32'h120, 1'b0, '0, 6'd5);
    push_only(32'h124, 1'b0, '0, 6'd6);
    resolve_only(1'b0, '0);
    do_reset();
    chk("post_reset_res_ready", res_ready, 1'b0);

    for (int n = 0; n < 400; n++) begin
      pt   = bit'($urandom_range(0, 1));
      ptgt = 32'h1000 + 32'($urandom_range(0, 3) * 16);
      rv   = ($urandom_range(0, 1) == 1);
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        rt   = mq[0].taken;
        rtgt = mq[0].target;
      end else begin
        rt   = bit'($urandom_range(0, 1));
        rtgt = 32'h1000 + 32'($urandom_range(0, 3) * 16);
      end
      step($urandom_range(0, 4) < 3, 32'($urandom) & 32'hFFFF_FFFC, pt, ptgt,
           6'($urandom), rv, rt, rtgt);
    end

`ifdef BRU_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      push_only(32'h2000 + 32'(i * 4), 1'b0, '0, 6'(i));
      if (i == 2 || i == 5 || i == 8) resolve_only(1'b1, 32'h3000);
      else resolve_only(1'b0, '0);
      idle();
    end
    chk("stat_branches", stat_branches, 32'(m_br));
    chk("stat_mispredicts", stat_mispredicts, 32'(m_mis));
    chk("stat_branches_10", stat_branches, 32'd10);
    chk("stat_mispredicts_3", stat_mispredicts, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
